// File: rtl/serial_pattern_driver_if.sv
// Load handshake and serial output bundle between a pattern source and serial_pattern_driver.
interface serial_pattern_driver_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned REP_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             done;

  // Requester side: issues patterns, consumes the serial stream.
  modport master (
    output load_valid, load_data, load_len, load_rep, abort,
    input  load_ready, x, x_valid, done
  );

  // Driver side.
  modport slave (
    input  load_valid, load_data, load_len, load_rep, abort,
    output load_ready, x, x_valid, done
  );
endinterface

// File: rtl/serial_pattern_driver.sv
// Parallel-to-serial pattern transmitter: shifts a captured word out MSB-first,
// repeating it load_rep+1 times, then pulses done for one cycle.
module serial_pattern_driver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned REP_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_pattern_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [LEN_W-1:0] eff_len_c;

  // Select bit idx of w via a shift, avoiding an over-wide index expression.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] idx);
    logic [WIDTH-1:0] s;
    s = w >> idx;
    return s[0];
  endfunction

  // Requested lengths beyond the word width are clamped to the full word.
  assign eff_len_c = (bus.load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.load_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      pass_q    <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      pass_q    <= pass_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    len_d     = len_q;
    bit_d     = bit_q;
    pass_d    = pass_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.load_valid) begin
          word_d  = bus.load_data;
          len_d   = eff_len_c;
          pass_d  = bus.load_rep;
          ready_d = 1'b0;
          if (eff_len_c == '0) begin
            // Zero-length request: nothing to send, repeats ignored.
            state_d = DONE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d   = SEND;
            bit_d     = eff_len_c - LEN_W'(1);
            x_d       = pick(bus.load_data, eff_len_c - LEN_W'(1));
            x_valid_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
          bit_d   = '0;
          pass_d  = '0;
          ready_d = 1'b1;
        end else if (bit_q == '0) begin
          if (pass_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Restart the captured word with no gap between passes.
            pass_d    = pass_q - REP_W'(1);
            bit_d     = len_q - LEN_W'(1);
            x_d       = pick(word_q, len_q - LEN_W'(1));
            x_valid_d = 1'b1;
          end
        end else begin
          bit_d     = bit_q - LEN_W'(1);
          x_d       = pick(word_q, bit_q - LEN_W'(1));
          x_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.load_ready = ready_q;
  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_pattern_driver.sv
// Scoreboard bench for serial_pattern_driver: stimulus queues expected bits/done,
// a negedge monitor pops and compares whatever the driver presents.
module tb_serial_pattern_driver;

  logic clk;
  logic reset;

  serial_pattern_driver_if #(.WIDTH(16), .LEN_W(5), .REP_W(4)) bus ();

  serial_pattern_driver #(.WIDTH(16), .LEN_W(5), .REP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic is_done;
    logic bit_v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_bits(input logic [63:0] bits, input int n);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e.is_done = 1'b0;
      e.bit_v   = bits[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.bit_v   = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid bit and every done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.x_valid === 1'b1) begin
        check("done_with_valid", 32'(bus.done), 32'd0);
        check("sb_nonempty_bit", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_kind_bit", 32'(e.is_done), 32'd0);
          check("x_bit", 32'(bus.x), 32'(e.bit_v));
        end
      end else begin
        check("x_idle_zero", 32'(bus.x), 32'd0);
        if (bus.done === 1'b1) begin
          check("sb_nonempty_done", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind_done", 32'(e.is_done), 32'd1);
          end
        end
      end
    end
  end

  // One full request with cycle-exact timing checks; bits is the hand-computed stream.
  task automatic run_req(input logic [15:0] data, input logic [4:0] len, input logic [3:0] rep,
                         input logic [63:0] bits, input int nbits);
    @(negedge clk);
    check("ready_before_req", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_len   = len;
    bus.load_rep   = rep;
    push_bits(bits, nbits);
    push_done();
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    for (int k = 1; k <= nbits; k++) begin
      @(negedge clk);
      check("x_valid_during_send", 32'(bus.x_valid), 32'd1);
      check("ready_low_send", 32'(bus.load_ready), 32'd0);
      bus.load_data = ~bus.load_data;
    end
    @(negedge clk);
    check("done_cycle", 32'(bus.done), 32'd1);
    check("x_valid_low_done", 32'(bus.x_valid), 32'd0);
    check("ready_low_done", 32'(bus.load_ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("ready_after_done", 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_len   = '0;
    bus.load_rep   = '0;
    bus.abort      = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_x_valid", 32'(bus.x_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic stream, repeats, and length edge cases.
    run_req(16'h2D6D, 5'd16, 4'd0, 64'h2D6D, 16);
    run_req(16'h000B, 5'd4,  4'd2, 64'hBBB,  12);
    run_req(16'h2D6D, 5'd0,  4'd3, 64'h0,    0);
    run_req(16'h2D6D, 5'd20, 4'd0, 64'h2D6D, 16);
    run_req(16'h0001, 5'd1,  4'd0, 64'h1,    1);

    // Abort on the 5th SEND edge: five bits seen, no done.
    @(negedge clk);
    check("ready_before_abort_req", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h2D6D;
    bus.load_len   = 5'd16;
    bus.load_rep   = 4'd0;
    push_bits(64'b00101, 5);
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("abort_x_valid", 32'(bus.x_valid), 32'd1);
      if (k == 5) bus.abort = 1'b1;
    end
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_x_valid_low", 32'(bus.x_valid), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_ready", 32'(bus.load_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("abort_still_idle", 32'(bus.x_valid | bus.done), 32'd0);
    end
    run_req(16'h000B, 5'd4, 4'd0, 64'hB, 4);

    // Asynchronous reset between edges during SEND.
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h2D6D;
    bus.load_len   = 5'd16;
    bus.load_rep   = 4'd0;
    push_bits(64'b001, 3);
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_x", 32'(bus.x), 32'd0);
    check("arst_x_valid", 32'(bus.x_valid), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_req(16'h000B, 5'd4, 4'd1, 64'hBB, 8);

    // Handshake hold-off: load_valid stays high while load_data churns.
    @(negedge clk);
    check("ready_before_holdoff", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h000B;
    bus.load_len   = 5'd4;
    bus.load_rep   = 4'd0;
    push_bits(64'hB, 4);
    push_done();
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("holdoff_ready_low", 32'(bus.load_ready), 32'd0);
      bus.load_data = (k % 2 == 1) ? 16'hFFFF : 16'h0000;
    end
    @(negedge clk);
    check("holdoff_ready_idle", 32'(bus.load_ready), 32'd1);
    bus.load_data = 16'h0005;
    push_bits(64'h5, 4);
    push_done();
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("holdoff_x_valid", 32'(bus.x_valid), 32'd1);
    end
    @(negedge clk);
    check("holdoff_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("holdoff_ready_back", 32'(bus.load_ready), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
